sap2_computer: RTL and testbench
================================

Name: sap2_computer

Overview:
- Top-level 8-bit SAP-2 style computer: one CPU, a program ROM and a data RAM on a shared 16-bit address / 8-bit data path.
- The CPU runs a multi-byte fetch FSM (1–3 bytes per instruction), then a microstep execute sequence.
- Initial scope is a minimal ISA: NOP, LDI, LDA absolute, STA absolute, HLT.

Parameters:
- DATA_WIDTH, 8, data bus and register width.
- ADDR_WIDTH, 16, address width.
- RESET_VECTOR, 16'hF000, first fetch address.
- STACK_INIT, 16'h01FF, stack pointer value after reset.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Memory map:
  - RAM: 8 KB at 0x0000–0x1FFF.
  - ROM: 4 KB at 0xF000–0xFFFF.
  - Other addresses read 0x00; writes to them are ignored.
  - Both memories have a 1-cycle synchronous read.
- Required instance and signal names (used by hierarchical probes):
  - Instances: u_cpu, u_ram, u_rom, and u_cpu.u_control_unit.
  - Top-level nets: cpu_mem_read, cpu_mem_address, cpu_instr_complete.
  - CPU nets: counter_out (PC), mar_out, opcode, temp_1_out, temp_2_out, a_out, flag_zero_o, flag_negative_o.
  - CPU control strobes: load_mar_pc, load_mar_addr_low, load_mar_addr_high, oe_ram, oe_temp_1, oe_temp_2, load_ir, load_temp_1, load_temp_2, load_a, load_status, load_sets_zn, pc_enable.
  - Control unit: current_microstep (values MS0..MS7).
- Memory tasks:
  - u_ram and u_rom each expose array mem.
  - u_ram provides tasks init_sim_ram and dump; u_rom provides init_sim_rom and dump.
  - Init tasks zero the whole array.
- Reset values:
  - PC = RESET_VECTOR; A, IR, temp_1, temp_2, MAR = 0; Z = N = 0.
  - All control strobes 0; FSM in STATIC_RESET_VECTOR.
- FSM after reset release (one cycle per state):
  - STATIC_RESET_VECTOR: PC loaded with 0xF000.
  - INIT_STACK_POINTER: SP = STACK_INIT.
  - Then fetch loop, per byte:
    - LATCH_ADDRESS: load_mar_pc=1, MAR<=PC.
    - READ_BYTE: cpu_mem_read=1, cpu_mem_address=MAR.
    - LATCH_BYTE: oe_ram=1, pc_enable=1, plus the destination strobe for the byte index: byte 1 load_ir, byte 2 load_temp_1, byte 3 load_temp_2.
    - CHK_MORE_BYTES: if bytes fetched < length(opcode), go to LATCH_ADDRESS; otherwise go to EXECUTE at MS0.
- Instruction lengths: NOP=1, HLT=1, LDI=2, LDA=3, STA=3.
- LDA abs (temp_1 = address low, temp_2 = address high), one microstep per cycle:
  - MS0: oe_temp_1.
  - MS1: oe_temp_1, load_mar_addr_low.
  - MS2: oe_temp_2.
  - MS3: oe_temp_2, load_mar_addr_high.
  - MS4: oe_ram, cpu_mem_address=MAR.
  - MS5: oe_ram, load_a, load_status, load_sets_zn, cpu_instr_complete=1.
  - Next cycle returns to LATCH_ADDRESS.
- STA abs: MS0–MS3 as LDA; MS4 drives the RAM write of A with cpu_instr_complete=1.
- LDI: MS0 oe_temp_1, load_a, load_status, load_sets_zn, cpu_instr_complete.
- NOP: MS0 cpu_instr_complete only.
- HLT: MS0 cpu_instr_complete. The FSM then enters HALTED and stays there until reset; PC holds (0xF004 when HLT is at 0xF003).
- Flags: when load_status and load_sets_zn are both high, Z = (value==0) and N = value[7]. STA does not touch the flags.
- Undefined opcodes execute as NOP.
- Reset asserted at any point overrides all activity and returns every register to its reset value on the next edge.
- PC increments with 16-bit wrap (0xFFFF→0x0000).

Decomposition:
- Shared package arch_defs_pkg:
  - DATA_WIDTH and ADDR_WIDTH.
  - Opcode constants: NOP=8'h00, HLT=8'h01, LDI=8'h10, LDA=8'h20, STA=8'h30.
  - Microstep enum MS0..MS7 and the fetch FSM state enum.
- Natural sub-module: control_unit. It takes opcode and FSM state, and outputs all strobes, current_microstep and instr_complete.
- Registers, memories and the bus mux stay in the cpu and top level.

Test Plan:
- Reset, then run 2 cycles → PC=0xF000; LATCH_ADDRESS has load_mar_pc=1; next cycle cpu_mem_read=1 and cpu_mem_address=0xF000.
- ROM F000: 20 34 12 01 and RAM[0x1234]=0x55:
  - Byte 1 load_ir, opcode=LDA.
  - Byte 2 load_temp_1, temp_1_out=0x34.
  - Byte 3 load_temp_2, temp_2_out=0x12.
  - MS0–MS5 strobes as specified.
  - At MS4, MAR=0x1234.
  - After completion A=0x55, Z=0, N=0.
- Same program → HLT decoded; PC=0xF004; FSM stays HALTED for 20 cycles.
- LDI 0x00 then LDI 0x80 → Z=1/N=0, then Z=0/N=1.
- STA 0x0010 after LDI 0xA5 → RAM[0x0010]=0xA5, flags unchanged.
- Assert reset during MS2 of LDA → next cycle STATIC_RESET_VECTOR, A=0, PC=0xF000.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the SAP-2 computer: widths, opcodes, FSM encodings.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_HLT = 8'h01;
  localparam logic [7:0] OP_LDI = 8'h10;
  localparam logic [7:0] OP_LDA = 8'h20;
  localparam logic [7:0] OP_STA = 8'h30;

  typedef enum logic [2:0] {
    MS0, MS1, MS2, MS3, MS4, MS5, MS6, MS7
  } microstep_t;

  typedef enum logic [2:0] {
    STATIC_RESET_VECTOR,
    INIT_STACK_POINTER,
    LATCH_ADDRESS,
    READ_BYTE,
    LATCH_BYTE,
    CHK_MORE_BYTES,
    EXECUTE,
    HALTED
  } fsm_state_t;

  // Number of bytes an instruction occupies; unknown opcodes are one-byte NOPs.
  function automatic logic [1:0] instr_length(input logic [7:0] op);
    case (op)
      OP_LDI:         instr_length = 2'd2;
      OP_LDA, OP_STA: instr_length = 2'd3;
      default:        instr_length = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/sap2_computer_control_unit.sv
// Decodes fetch state, opcode and microstep into the CPU control strobes.
// Owns the microstep counter that sequences the execute phase.
module control_unit
  import arch_defs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  fsm_state_t state,
  input  logic [7:0] opcode,
  input  logic [1:0] byte_cnt,
  output microstep_t current_microstep,
  output logic       load_mar_pc,
  output logic       load_mar_addr_low,
  output logic       load_mar_addr_high,
  output logic       oe_ram,
  output logic       oe_temp_1,
  output logic       oe_temp_2,
  output logic       load_ir,
  output logic       load_temp_1,
  output logic       load_temp_2,
  output logic       load_a,
  output logic       load_status,
  output logic       load_sets_zn,
  output logic       pc_enable,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_complete
);

  // Microstep advances each execute cycle and restarts at MS0 on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_microstep <= MS0;
    end else if (state == EXECUTE && !instr_complete) begin
      current_microstep <= microstep_t'(current_microstep + 3'd1);
    end else begin
      current_microstep <= MS0;
    end
  end

  // Strobe decode: fetch strobes from the state, execute strobes from opcode/microstep.
  always_comb begin
    load_mar_pc        = 1'b0;
    load_mar_addr_low  = 1'b0;
    load_mar_addr_high = 1'b0;
    oe_ram             = 1'b0;
    oe_temp_1          = 1'b0;
    oe_temp_2          = 1'b0;
    load_ir            = 1'b0;
    load_temp_1        = 1'b0;
    load_temp_2        = 1'b0;
    load_a             = 1'b0;
    load_status        = 1'b0;
    load_sets_zn       = 1'b0;
    pc_enable          = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    instr_complete     = 1'b0;
    case (state)
      LATCH_ADDRESS: load_mar_pc = 1'b1;
      READ_BYTE:     mem_read = 1'b1;
      LATCH_BYTE: begin
        oe_ram    = 1'b1;
        pc_enable = 1'b1;
        case (byte_cnt)
          2'd0:    load_ir = 1'b1;
          2'd1:    load_temp_1 = 1'b1;
          default: load_temp_2 = 1'b1;
        endcase
      end
      EXECUTE: begin
        case (opcode)
          OP_LDI: begin
            oe_temp_1      = 1'b1;
            load_a         = 1'b1;
            load_status    = 1'b1;
            load_sets_zn   = 1'b1;
            instr_complete = 1'b1;
          end
          OP_LDA, OP_STA: begin
            case (current_microstep)
              MS0: oe_temp_1 = 1'b1;
              MS1: begin
                oe_temp_1         = 1'b1;
                load_mar_addr_low = 1'b1;
              end
              MS2: oe_temp_2 = 1'b1;
              MS3: begin
                oe_temp_2          = 1'b1;
                load_mar_addr_high = 1'b1;
              end
              MS4: begin
                if (opcode == OP_LDA) begin
                  oe_ram   = 1'b1;
                  mem_read = 1'b1;
                end else begin
                  mem_write      = 1'b1;
                  instr_complete = 1'b1;
                end
              end
              MS5: begin
                oe_ram         = 1'b1;
                load_a         = 1'b1;
                load_status    = 1'b1;
                load_sets_zn   = 1'b1;
                instr_complete = 1'b1;
              end
              default: instr_complete = 1'b1;
            endcase
          end
          default: instr_complete = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap2_computer_cpu.sv
// SAP-2 CPU datapath and fetch FSM. The internal bus carries the value
// selected by the oe_* strobes; registers latch it under their load strobes.
module sap2_computer_cpu
  import arch_defs_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hF000,
  parameter logic [15:0] STACK_INIT   = 16'h01FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  instr_complete
);

  fsm_state_t            state;
  microstep_t            current_microstep;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] counter_out;
  logic [ADDR_WIDTH-1:0] mar_out;
  logic [ADDR_WIDTH-1:0] sp;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] temp_1_out;
  logic [DATA_WIDTH-1:0] temp_2_out;
  logic [DATA_WIDTH-1:0] a_out;
  logic [DATA_WIDTH-1:0] data_bus;
  logic                  flag_zero_o;
  logic                  flag_negative_o;

  logic load_mar_pc, load_mar_addr_low, load_mar_addr_high;
  logic oe_ram, oe_temp_1, oe_temp_2;
  logic load_ir, load_temp_1, load_temp_2, load_a;
  logic load_status, load_sets_zn, pc_enable;

  // The stack pointer is initialised but not yet used by the minimal ISA.
  logic unused_sp;
  assign unused_sp = ^sp;

  assign mem_address = mar_out;
  assign mem_wdata   = a_out;

  control_unit u_control_unit (
    .clk                (clk),
    .reset              (reset),
    .state              (state),
    .opcode             (opcode),
    .byte_cnt           (byte_cnt),
    .current_microstep  (current_microstep),
    .load_mar_pc        (load_mar_pc),
    .load_mar_addr_low  (load_mar_addr_low),
    .load_mar_addr_high (load_mar_addr_high),
    .oe_ram             (oe_ram),
    .oe_temp_1          (oe_temp_1),
    .oe_temp_2          (oe_temp_2),
    .load_ir            (load_ir),
    .load_temp_1        (load_temp_1),
    .load_temp_2        (load_temp_2),
    .load_a             (load_a),
    .load_status        (load_status),
    .load_sets_zn       (load_sets_zn),
    .pc_enable          (pc_enable),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .instr_complete     (instr_complete)
  );

  // Internal bus mux: memory data has priority over the temp registers.
  always_comb begin
    data_bus = '0;
    if (oe_ram)         data_bus = mem_rdata;
    else if (oe_temp_1) data_bus = temp_1_out;
    else if (oe_temp_2) data_bus = temp_2_out;
  end

  // Fetch/execute FSM plus every architectural register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= STATIC_RESET_VECTOR;
      byte_cnt        <= 2'd0;
      counter_out     <= RESET_VECTOR;
      mar_out         <= '0;
      sp              <= '0;
      opcode          <= '0;
      temp_1_out      <= '0;
      temp_2_out      <= '0;
      a_out           <= '0;
      flag_zero_o     <= 1'b0;
      flag_negative_o <= 1'b0;
    end else begin
      if (load_mar_pc)        mar_out <= counter_out;
      if (load_mar_addr_low)  mar_out[7:0] <= data_bus;
      if (load_mar_addr_high) mar_out[15:8] <= data_bus;
      if (load_ir)            opcode <= data_bus;
      if (load_temp_1)        temp_1_out <= data_bus;
      if (load_temp_2)        temp_2_out <= data_bus;
      if (load_a)             a_out <= data_bus;
      if (pc_enable)          counter_out <= counter_out + 16'd1;
      if (load_status && load_sets_zn) begin
        flag_zero_o     <= (data_bus == '0);
        flag_negative_o <= data_bus[7];
      end
      case (state)
        STATIC_RESET_VECTOR: begin
          counter_out <= RESET_VECTOR;
          state       <= INIT_STACK_POINTER;
        end
        INIT_STACK_POINTER: begin
          sp    <= STACK_INIT;
          state <= LATCH_ADDRESS;
        end
        LATCH_ADDRESS: state <= READ_BYTE;
        READ_BYTE:     state <= LATCH_BYTE;
        LATCH_BYTE: begin
          byte_cnt <= byte_cnt + 2'd1;
          state    <= CHK_MORE_BYTES;
        end
        CHK_MORE_BYTES: begin
          if (byte_cnt < instr_length(opcode)) state <= LATCH_ADDRESS;
          else                                 state <= EXECUTE;
        end
        EXECUTE: begin
          if (instr_complete) begin
            byte_cnt <= 2'd0;
            state    <= (opcode == OP_HLT) ? HALTED : LATCH_ADDRESS;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: rtl/sap2_computer_ram.sv
// 8 KB data RAM with a registered (1-cycle) read port and a synchronous write.
module sap2_computer_ram #(
  parameter int DEPTH = 8192
) (
  input  logic        clk,
  input  logic [12:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:DEPTH-1];

  // Write port and registered read port; read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (write_en) mem[addr] <= wdata;
    if (read_en)  rdata <= mem[addr];
  end

  task automatic init_sim_ram();
    for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
  endtask

  task automatic dump(input logic [12:0] a, output logic [7:0] d);
    d = mem[a];
  endtask

endmodule

// File: rtl/sap2_computer_rom.sv
// 4 KB program ROM with a registered (1-cycle) read port.
module sap2_computer_rom #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic [11:0] addr,
  input  logic        read_en,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:DEPTH-1];

  // Registered read port.
  always_ff @(posedge clk) begin
    if (read_en) rdata <= mem[addr];
  end

  task automatic init_sim_rom();
    for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
  endtask

  task automatic dump(input logic [11:0] a, output logic [7:0] d);
    d = mem[a];
  endtask

endmodule

// File: rtl/sap2_computer.sv
// SAP-2 computer top: CPU, 8 KB RAM at 0x0000, 4 KB ROM at 0xF000.
// Reads from unmapped addresses return 0x00; writes there are dropped.
module sap2_computer #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_WIDTH   = 16,
  parameter logic [15:0] RESET_VECTOR = 16'hF000,
  parameter logic [15:0] STACK_INIT   = 16'h01FF
) (
  input logic clk,
  input logic reset
);

  logic [ADDR_WIDTH-1:0] cpu_mem_address;
  logic [DATA_WIDTH-1:0] cpu_mem_wdata;
  logic [DATA_WIDTH-1:0] cpu_mem_rdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rom_rdata;
  logic                  cpu_mem_read;
  logic                  cpu_mem_write;
  logic                  cpu_instr_complete;
  logic                  ram_sel;
  logic                  rom_sel;
  logic [1:0]            rd_region;

  assign ram_sel = (cpu_mem_address[15:13] == 3'b000);
  assign rom_sel = (cpu_mem_address[15:12] == 4'hF);

  sap2_computer_cpu #(
    .RESET_VECTOR (RESET_VECTOR),
    .STACK_INIT   (STACK_INIT)
  ) u_cpu (
    .clk            (clk),
    .reset          (reset),
    .mem_rdata      (cpu_mem_rdata),
    .mem_address    (cpu_mem_address),
    .mem_wdata      (cpu_mem_wdata),
    .mem_read       (cpu_mem_read),
    .mem_write      (cpu_mem_write),
    .instr_complete (cpu_instr_complete)
  );

  sap2_computer_ram u_ram (
    .clk      (clk),
    .addr     (cpu_mem_address[12:0]),
    .read_en  (cpu_mem_read & ram_sel),
    .write_en (cpu_mem_write & ram_sel),
    .wdata    (cpu_mem_wdata),
    .rdata    (ram_rdata)
  );

  sap2_computer_rom u_rom (
    .clk     (clk),
    .addr    (cpu_mem_address[11:0]),
    .read_en (cpu_mem_read & rom_sel),
    .rdata   (rom_rdata)
  );

  // Remember which region the last read targeted so the returned byte is steered correctly.
  always_ff @(posedge clk) begin
    if (reset)             rd_region <= 2'b00;
    else if (cpu_mem_read) rd_region <= {rom_sel, ram_sel};
  end

  // Read-data mux; unmapped reads return zero.
  always_comb begin
    cpu_mem_rdata = '0;
    if (rd_region[0])      cpu_mem_rdata = ram_rdata;
    else if (rd_region[1]) cpu_mem_rdata = rom_rdata;
  end

endmodule

// File: tb/tb_sap2_computer.sv
// Directed bench for sap2_computer: loads small programs into ROM/RAM,
// steps the machine and compares probed state against queued expectations.
module tb_sap2_computer;
  import arch_defs_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  sap2_computer u_dut (
    .clk   (clk),
    .reset (reset)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {oe_ram, oe_temp_1, oe_temp_2, load_mar_addr_low, load_mar_addr_high,
  //  load_a, load_status, load_sets_zn, cpu_instr_complete}
  wire [8:0] exec_strobes = {u_dut.u_cpu.oe_ram, u_dut.u_cpu.oe_temp_1,
                             u_dut.u_cpu.oe_temp_2, u_dut.u_cpu.load_mar_addr_low,
                             u_dut.u_cpu.load_mar_addr_high, u_dut.u_cpu.load_a,
                             u_dut.u_cpu.load_status, u_dut.u_cpu.load_sets_zn,
                             u_dut.cpu_instr_complete};
  wire [15:0] pc    = u_dut.u_cpu.counter_out;
  wire [7:0]  a_reg = u_dut.u_cpu.a_out;
  wire [1:0]  zn    = {u_dut.u_cpu.flag_zero_o, u_dut.u_cpu.flag_negative_o};

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected value queued (got %h)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic rom_byte(input logic [15:0] addr, input logic [7:0] d);
    u_dut.u_rom.mem[addr[11:0]] <= d;
  endtask

  task automatic ram_byte(input logic [15:0] addr, input logic [7:0] d);
    u_dut.u_ram.mem[addr[12:0]] <= d;
  endtask

  task automatic clear_mem();
    u_dut.u_ram.init_sim_ram();
    u_dut.u_rom.init_sim_rom();
  endtask

  // Releases reset and advances to the first LATCH_ADDRESS (two cycles).
  task automatic release_reset();
    reset = 1'b0;
    step(2);
  endtask

  task automatic wait_state(input fsm_state_t s, input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && u_dut.u_cpu.state != s; i++) @(negedge clk);
    expect_val(32'd1);
    check(tag, {31'd0, u_dut.u_cpu.state == s});
  endtask

  // Waits for the completion cycle, then moves one cycle past it.
  task automatic wait_complete(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && !u_dut.cpu_instr_complete; i++) @(negedge clk);
    expect_val(32'd1);
    check(tag, {31'd0, u_dut.cpu_instr_complete});
    step(1);
  endtask

  logic [8:0] lda_exp [6];
  logic [7:0] ram_val;

  initial begin
    checks = 0;
    errors = 0;
    lda_exp[0] = 9'b010000000;
    lda_exp[1] = 9'b010100000;
    lda_exp[2] = 9'b001000000;
    lda_exp[3] = 9'b001010000;
    lda_exp[4] = 9'b100000000;
    lda_exp[5] = 9'b100001111;

    // ---- program 1: LDA 0x1234 ; HLT ----
    reset = 1'b1;
    clear_mem();
    rom_byte(16'hF000, 8'h20); rom_byte(16'hF001, 8'h34);
    rom_byte(16'hF002, 8'h12); rom_byte(16'hF003, 8'h01);
    ram_byte(16'h1234, 8'h55);
    step(3);
    expect_val(16'hF000); check("rst_pc", pc);
    expect_val(8'h00);    check("rst_a", a_reg);
    expect_val(16'h0000); check("rst_mar", u_dut.u_cpu.mar_out);
    expect_val(2'b00);    check("rst_zn", zn);
    expect_val(STATIC_RESET_VECTOR); check("rst_state", u_dut.u_cpu.state);
    expect_val(9'd0);     check("rst_strobes", exec_strobes);
    expect_val(3'b000);   check("rst_fetch_strobes",
                                {u_dut.u_cpu.load_mar_pc, u_dut.u_cpu.pc_enable, u_dut.u_cpu.load_ir});

    release_reset();
    expect_val(LATCH_ADDRESS); check("la_state", u_dut.u_cpu.state);
    expect_val(1'b1);     check("la_load_mar_pc", u_dut.u_cpu.load_mar_pc);
    expect_val(16'hF000); check("la_pc", pc);
    step(1);
    expect_val(1'b1);     check("rd_mem_read", u_dut.cpu_mem_read);
    expect_val(16'hF000); check("rd_address", u_dut.cpu_mem_address);
    step(1);
    expect_val(1'b1);     check("b1_load_ir", u_dut.u_cpu.load_ir);
    step(1);
    expect_val(OP_LDA);   check("b1_opcode", u_dut.u_cpu.opcode);
    step(3);
    expect_val(1'b1);     check("b2_load_temp_1", u_dut.u_cpu.load_temp_1);
    step(1);
    expect_val(8'h34);    check("b2_temp_1", u_dut.u_cpu.temp_1_out);
    step(3);
    expect_val(1'b1);     check("b3_load_temp_2", u_dut.u_cpu.load_temp_2);
    step(1);
    expect_val(8'h12);    check("b3_temp_2", u_dut.u_cpu.temp_2_out);
    expect_val(16'hF003); check("b3_pc", pc);
    step(1);
    for (int m = 0; m < 6; m++) begin
      expect_val(m);          check("lda_microstep", u_dut.u_cpu.u_control_unit.current_microstep);
      expect_val(lda_exp[m]); check("lda_strobes", exec_strobes);
      if (m == 4) begin
        expect_val(16'h1234); check("lda_ms4_mar", u_dut.u_cpu.mar_out);
      end
      step(1);
    end
    expect_val(LATCH_ADDRESS); check("lda_next_state", u_dut.u_cpu.state);
    expect_val(8'h55);    check("lda_a", a_reg);
    expect_val(2'b00);    check("lda_zn", zn);
    wait_state(HALTED, 30, "hlt_reached");
    expect_val(16'hF004); check("hlt_pc", pc);
    step(20);
    expect_val(HALTED);   check("hlt_stays", u_dut.u_cpu.state);
    expect_val(16'hF004); check("hlt_pc_hold", pc);

    // ---- program 2: LDI 00 ; undefined FF ; LDI 80 ; LDI A5 ; STA 0x0010 ; HLT ----
    reset = 1'b1;
    step(1);
    clear_mem();
    rom_byte(16'hF000, 8'h10); rom_byte(16'hF001, 8'h00);
    rom_byte(16'hF002, 8'hFF);
    rom_byte(16'hF003, 8'h10); rom_byte(16'hF004, 8'h80);
    rom_byte(16'hF005, 8'h10); rom_byte(16'hF006, 8'hA5);
    rom_byte(16'hF007, 8'h30); rom_byte(16'hF008, 8'h10); rom_byte(16'hF009, 8'h00);
    rom_byte(16'hF00A, 8'h01);
    ram_byte(16'h0010, 8'h3C);
    step(2);
    release_reset();
    wait_complete(40, "ldi0_done");
    expect_val(8'h00);    check("ldi0_a", a_reg);
    expect_val(2'b10);    check("ldi0_zn", zn);
    wait_complete(40, "undef_done");
    expect_val(16'hF003); check("undef_pc", pc);
    expect_val(2'b10);    check("undef_zn", zn);
    wait_complete(40, "ldi80_done");
    expect_val(8'h80);    check("ldi80_a", a_reg);
    expect_val(2'b01);    check("ldi80_zn", zn);
    wait_complete(40, "ldia5_done");
    expect_val(8'hA5);    check("ldia5_a", a_reg);
    wait_complete(40, "sta_done");
    u_dut.u_ram.dump(13'h0010, ram_val);
    expect_val(8'hA5);    check("sta_ram", ram_val);
    expect_val(2'b01);    check("sta_zn_unchanged", zn);
    wait_state(HALTED, 30, "p2_halted");
    expect_val(16'hF00B); check("p2_pc", pc);

    // ---- program 3: LDI 77 ; LDA 0x1234 ; HLT, reset during LDA MS2 ----
    reset = 1'b1;
    step(1);
    clear_mem();
    rom_byte(16'hF000, 8'h10); rom_byte(16'hF001, 8'h77);
    rom_byte(16'hF002, 8'h20); rom_byte(16'hF003, 8'h34); rom_byte(16'hF004, 8'h12);
    rom_byte(16'hF005, 8'h01);
    ram_byte(16'h1234, 8'hC3);
    step(2);
    release_reset();
    for (int i = 0; i < 60 && !(u_dut.u_cpu.state == EXECUTE && u_dut.u_cpu.opcode == OP_LDA &&
                                u_dut.u_cpu.u_control_unit.current_microstep == MS2); i++)
      @(negedge clk);
    expect_val(MS2);      check("p3_at_ms2", u_dut.u_cpu.u_control_unit.current_microstep);
    expect_val(8'h77);    check("p3_a_before", a_reg);
    reset = 1'b1;
    step(1);
    expect_val(STATIC_RESET_VECTOR); check("p3_rst_state", u_dut.u_cpu.state);
    expect_val(8'h00);    check("p3_rst_a", a_reg);
    expect_val(16'hF000); check("p3_rst_pc", pc);
    expect_val(9'd0);     check("p3_rst_strobes", exec_strobes);
    release_reset();
    wait_state(HALTED, 60, "p3_halted");
    expect_val(8'hC3);    check("p3_final_a", a_reg);
    expect_val(2'b01);    check("p3_final_zn", zn);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
